// File: rtl/imem_loader.sv
// Instruction-memory loader: streams a program image into the write port,
// verifies a trailing checksum word, and holds the CPU until the load succeeds.
module imem_loader #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded,
  output logic [2:0]        dbg_state
);

  // Handshake: a word moves on any cycle where s_valid && s_ready are both 1.
  // s_ready is a registered decode of the next state (1 only in LOAD/CHECK); the
  // source must hold s_data stable while s_valid=1 and s_ready=0.

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic              s_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_waddr_q;
  logic [31:0]       mem_wdata_q;
  logic              cpu_hold_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   len_q;
  logic [31:0]       sum_q;

  logic xfer;
  logic len_ok;
  logic last_word;
  logic can_start;
  logic legal_start;

  assign xfer        = s_valid && s_ready_q;
  assign len_ok      = (len != '0) && (len <= DEPTH_L);
  assign last_word   = (count_q == (len_q - 1'b1));
  assign can_start   = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);
  assign legal_start = can_start && start && len_ok;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = len_ok ? ST_LOAD : ST_ERROR;
        end
      end
      ST_LOAD: begin
        if (xfer && last_word) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (xfer) state_d = (s_data == sum_q) ? ST_DONE : ST_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decode the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      s_ready_q  <= 1'b0;
      cpu_hold_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_ready_q  <= (state_d == ST_LOAD) || (state_d == ST_CHECK);
      cpu_hold_q <= (state_d != ST_DONE);
      busy_q     <= (state_d == ST_LOAD) || (state_d == ST_CHECK);
      done_q     <= (state_d == ST_DONE);
      err_q      <= (state_d == ST_ERROR);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      words_q     <= '0;
      count_q     <= '0;
      len_q       <= '0;
      sum_q       <= '0;
    end else begin
      mem_we_q <= 1'b0;
      if (legal_start) begin
        len_q   <= len;
        count_q <= '0;
        sum_q   <= '0;
        words_q <= '0;
      end
      // The write lands one cycle after the transfer; the checksum word is never written.
      if (state_q == ST_LOAD && xfer) begin
        mem_we_q    <= 1'b1;
        mem_waddr_q <= count_q[ADDR_W-1:0];
        mem_wdata_q <= s_data;
        sum_q       <= sum_q + s_data;
        count_q     <= count_q + 1'b1;
        words_q     <= words_q + 1'b1;
      end
    end
  end

  assign s_ready      = s_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_waddr    = mem_waddr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: expected memory writes go through a scoreboard queue,
// status outputs are checked directly against hand-computed values.
module tb_imem_loader;

  localparam int ADDR_W = 4;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   len;
  logic              s_valid;
  logic [31:0]       s_data;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;
  logic [2:0]        dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [ADDR_W+31:0] exp_q[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
    .words_loaded(words_loaded), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every write strobe pops one expected {addr,data}
  always @(negedge clk) begin
    if (mem_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, none expected", mem_waddr, mem_wdata);
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        if ({mem_waddr, mem_wdata} !== e) begin
          n_fail++;
          $display("FAIL mem_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   mem_waddr, mem_wdata, e[ADDR_W+31:32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Driver tasks: all begin and end just after a negedge
  task automatic do_start(input logic [ADDR_W:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input int gap);
    int bound;
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    bound   = 0;
    while (!s_ready && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    if (bound >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL handshake_timeout: s_ready=0 after 50 cycles, expected 1");
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic expect_write(input int a, input logic [31:0] d);
    logic [ADDR_W-1:0] aa;
    aa = a[ADDR_W-1:0];
    exp_q.push_back({aa, d});
  endtask

  logic [31:0] img [3];

  initial begin
    img[0] = 32'h20080001;
    img[1] = 32'h21090002;
    img[2] = 32'h012A4020;

    reset = 1'b1; start = 1'b0; len = '0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_waddr", 32'(mem_waddr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);

    // Test 1: clean load of three words
    do_start(5'd3);
    check("t1_s_ready_latency", 32'(s_ready), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      expect_write(i, img[i]);
      send_word(img[i], 0);
    end
    check("t1_busy_check", 32'(busy), 32'd1);
    send_word(32'h423B4023, 0);
    check("t1_done", 32'(done), 32'd1);
    check("t1_cpu_hold", 32'(cpu_hold), 32'd0);
    check("t1_words", 32'(words_loaded), 32'd3);
    check("t1_s_ready_off", 32'(s_ready), 32'd0);

    // Test 2: same image, wrong checksum
    do_start(5'd3);
    check("t2_cpu_hold_reload", 32'(cpu_hold), 32'd1);
    for (int i = 0; i < 3; i++) begin
      expect_write(i, img[i]);
      send_word(img[i], 0);
    end
    send_word(32'h423B4024, 0);
    check("t2_err", 32'(err), 32'd1);
    check("t2_done", 32'(done), 32'd0);
    check("t2_cpu_hold", 32'(cpu_hold), 32'd1);

    // Test 3: illegal lengths go straight to ERROR
    do_start(5'd0);
    check("t3_len0_err", 32'(err), 32'd1);
    check("t3_len0_s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    do_start(5'd17);
    check("t3_len17_err", 32'(err), 32'd1);
    check("t3_len17_s_ready", 32'(s_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("t3_s_ready_stays_low", 32'(s_ready), 32'd0);

    // Test 4: full depth, all-ones words, wrapping sum
    do_start(5'd16);
    for (int i = 0; i < 16; i++) begin
      expect_write(i, 32'hFFFFFFFF);
      send_word(32'hFFFFFFFF, 0);
    end
    send_word(32'hFFFFFFF0, 0);
    check("t4_done", 32'(done), 32'd1);
    check("t4_words", 32'(words_loaded), 32'd16);

    // Test 5: gaps in s_valid and a stray start during LOAD
    do_start(5'd3);
    expect_write(0, img[0]);
    send_word(img[0], 0);
    do_start(5'd1);
    check("t5_start_ignored", 32'(busy), 32'd1);
    expect_write(1, img[1]);
    send_word(img[1], 1);
    expect_write(2, img[2]);
    send_word(img[2], 1);
    send_word(32'h423B4023, 0);
    check("t5_done", 32'(done), 32'd1);
    check("t5_words", 32'(words_loaded), 32'd3);

    // Test 6: reset after two words of a three-word load
    do_start(5'd3);
    expect_write(0, img[0]);
    send_word(img[0], 0);
    expect_write(1, img[1]);
    send_word(img[1], 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_state_idle", 32'(dbg_state), 32'd0);
    check("t6_s_ready", 32'(s_ready), 32'd0);
    check("t6_cpu_hold", 32'(cpu_hold), 32'd1);
    check("t6_words", 32'(words_loaded), 32'd0);
    repeat (4) @(negedge clk);
    do_start(5'd3);
    for (int i = 0; i < 3; i++) begin
      expect_write(i, img[i]);
      send_word(img[i], 0);
    end
    send_word(32'h423B4023, 0);
    check("t6_reload_done", 32'(done), 32'd1);

    repeat (3) @(negedge clk);
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
